csr_file_m: RTL and testbench
=============================

Name: csr_file_m

Overview:
Parametrised machine-mode CSR file for the RV32 core. It supports atomic read/write/set/clear CSR operations and 64-bit auto-incrementing mcycle/minstret counters. It also provides hardware trap-entry/mret updates of mstatus/mepc/mcause and flags illegal accesses. It sits between the decode/execute stage and the trap controller.

Parameters:
XLEN, 32, data width of every CSR port; only 32 is supported, and counters are always 64 bits split into low/high halves.
MISA_VAL, 32'h40000100, read-only value of misa (RV32I).
MVENDORID, 0, read-only mvendorid.
MARCHID, 0, read-only marchid.
MIMPID, 0, read-only mimpid.
HART_ID, 0, read-only mhartid.
MTVEC_RST, 32'h00000100, reset value of mtvec.

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  asynchronous reset, active-high
csr_en_i  in  1  CSR access strobe, one cycle per access
csr_op_i  in  2  00 read-only, 01 write, 10 set (OR), 11 clear (AND-NOT)
csr_addr_i  in  12  CSR address
csr_wdata_i  in  XLEN  operand for write/set/clear
csr_rdata_o  out  XLEN  registered read data (pre-modification value)
csr_rvalid_o  out  1  high one cycle after an accepted csr_en_i
csr_illegal_o  out  1  high with csr_rvalid_o when the access is illegal
instret_i  in  1  one instruction retired this cycle
trap_i  in  1  trap entry strobe
trap_cause_i  in  XLEN  mcause value for trap entry
trap_pc_i  in  XLEN  faulting PC for mepc
mret_i  in  1  mret strobe
irq_i  in  3  {MEIP, MTIP, MSIP} level inputs
mtvec_o  out  XLEN  current mtvec
mepc_o  out  XLEN  current mepc
mie_o  out  1  mstatus.MIE
irq_pending_o  out  1  |(mip & mie) & mstatus.MIE

Behaviour:
- Address map:
  - Read-only: misa 0x301, mvendorid 0xF11, marchid 0xF12, mimpid 0xF13, mhartid 0xF14.
  - Read-write: mstatus 0x300, mie 0x304, mtvec 0x305, mcounteren 0x306, mepc 0x341, mcause 0x342, mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82.
  - Read-only, write ignored and legal: mip 0x344.
- misa is read-only here, and writes to it are ignored without being flagged illegal.
- Reset values:
  - mstatus = 32'h00001800 (MPP = 11 hardwired).
  - mtvec = MTVEC_RST.
  - mie, mepc, mcause, mcounteren, mcycle, minstret = 0.
  - csr_rdata_o = 0, csr_rvalid_o = 0, csr_illegal_o = 0.
- Access latency:
  - An access with csr_en_i high in cycle N gives csr_rdata_o, csr_rvalid_o and csr_illegal_o in cycle N+1.
  - csr_rdata_o is the value before any modification made in cycle N.
  - When csr_en_i is low, csr_rvalid_o and csr_illegal_o are 0 and csr_rdata_o holds its value.
- Write value: new = wdata (01), old | wdata (10), old & ~wdata (11), applied at the end of cycle N.
- Illegal accesses:
  - Unmapped address with any op: illegal, rdata = 0, no state change.
  - Op != 00 to 0xF11..0xF14: illegal, rdata = the read-only value, no state change.
- Write masks:
  - mstatus: only bits 3 (MIE) and 7 (MPIE) are writable; bits 12:11 read 11; all others read 0.
  - mie: only bits 3, 7, 11 are writable.
  - mtvec: bits 1:0 read 0 (direct mode only).
  - mepc: bits 1:0 read 0.
  - mcounteren: bits 2:0 are writable.
- mip: reads {20'b0, irq_i[2], 3'b0, irq_i[1], 3'b0, irq_i[0], 3'b0} (bits 11, 7, 3).
- Counters:
  - mcycle increments by 1 every cycle out of reset.
  - minstret increments when instret_i is high.
  - Both are 64-bit; the low half carries into the high half; 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
  - A CSR write to either half in a cycle replaces that half with the written value and suppresses the increment of the whole 64-bit counter for that cycle. The other half is unchanged, with no carry.
- Trap entry (trap_i):
  - mepc <= {trap_pc_i[31:2], 2'b00}.
  - mcause <= trap_cause_i.
  - MPIE <= MIE, MIE <= 0.
- mret (mret_i): MIE <= MPIE, MPIE <= 1.
- Priority per register, same cycle: trap_i > mret_i > CSR write.
  - A losing CSR write to the same register is dropped, but is still reported with rvalid and is not illegal.
  - CSR writes to other registers proceed.
- Reset asserted mid-operation: all state returns to reset values immediately, and any pending rvalid is cancelled.
- irq_pending_o: combinational from current registers and irq_i.

Test Plan:
1. Reset, then read 0x301, 0xF14 and 0x300 -> rdata 32'h40000100, HART_ID, 32'h00001800, each with rvalid one cycle later and illegal = 0.
2. Write mtvec 32'h0000_0203, then read -> 32'h0000_0200. Set mie 32'hFFFF_FFFF, then clear with 32'h8 -> mie reads 32'h880, and the set access returns old value 0.
3. Write 0xF11 and read 0x7C0 -> csr_illegal_o = 1 with rvalid, mvendorid unchanged, and rdata for 0x7C0 = 0.
4. Write mcycle = 32'hFFFF_FFFE and mcycleh = 0, run 3 cycles, read 0xB80 -> 1, and low half wrapped. Writing in the same cycle suppresses the increment.
5. Set MIE, pulse trap_i with cause 32'h8000_0007 and pc 32'h1236 -> mepc 32'h1234, mcause as given, MIE = 0, MPIE = 1. Then mret -> MIE = 1, MPIE = 1.
6. Trap_i coincident with a mepc write of 32'hAAAA_AAA8 -> mepc = trap pc. Assert rst_i asynchronously mid-access -> rvalid = 0 immediately and all CSRs return to reset values.

Source files
------------

// File: rtl/csr_file_m_if.sv
// CSR access bus between decode/execute and the machine-mode CSR file.
// The core drives the request side; the CSR file returns registered read data.
interface csr_file_m_if #(
  parameter int unsigned XLEN = 32
);
  logic            csr_en_i;
  logic [1:0]      csr_op_i;
  logic [11:0]     csr_addr_i;
  logic [XLEN-1:0] csr_wdata_i;
  logic [XLEN-1:0] csr_rdata_o;
  logic            csr_rvalid_o;
  logic            csr_illegal_o;

  modport master (
    output csr_en_i, csr_op_i, csr_addr_i, csr_wdata_i,
    input  csr_rdata_o, csr_rvalid_o, csr_illegal_o
  );

  modport slave (
    input  csr_en_i, csr_op_i, csr_addr_i, csr_wdata_i,
    output csr_rdata_o, csr_rvalid_o, csr_illegal_o
  );
endinterface

// File: rtl/csr_file_m.sv
// Machine-mode CSR file for the RV32 core: atomic CSR ops, 64-bit cycle/instret
// counters, trap-entry/mret updates of mstatus/mepc/mcause and illegal-access flagging.
module csr_file_m #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] MISA_VAL  = 32'h40000100,
  parameter logic [XLEN-1:0] MVENDORID = '0,
  parameter logic [XLEN-1:0] MARCHID   = '0,
  parameter logic [XLEN-1:0] MIMPID    = '0,
  parameter logic [XLEN-1:0] HART_ID   = '0,
  parameter logic [XLEN-1:0] MTVEC_RST = 32'h00000100
) (
  input  logic            clk_i,
  input  logic            rst_i,
  csr_file_m_if.slave     bus,
  input  logic            instret_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic            mret_i,
  input  logic [2:0]      irq_i,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            mie_o,
  output logic            irq_pending_o
);

  localparam logic [XLEN-1:0] ALIGN4_MASK = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [XLEN-1:0] MIE_WMASK   = 32'h00000888;
  localparam logic [XLEN-1:0] MCNT_WMASK  = 32'h00000007;

  typedef enum logic [1:0] {
    K_NONE,    // unmapped
    K_RW,      // read-write
    K_RO_IGN,  // read-only, writes silently ignored
    K_ID       // read-only, writes illegal
  } kind_t;

  logic            mst_mie_q, mst_mpie_q;
  logic [XLEN-1:0] mie_q, mtvec_q, mcounteren_q, mepc_q, mcause_q;
  logic [63:0]     mcycle_q, minstret_q;

  kind_t           kind;
  logic [XLEN-1:0] rd_val, wval, mstatus_val, mip_val;
  logic            wr;

  always_comb begin
    mstatus_val        = '0;
    mstatus_val[12:11] = 2'b11;
    mstatus_val[7]     = mst_mpie_q;
    mstatus_val[3]     = mst_mie_q;
    mip_val            = '0;
    mip_val[11]        = irq_i[2];
    mip_val[7]         = irq_i[1];
    mip_val[3]         = irq_i[0];
  end

  always_comb begin
    rd_val = '0;
    kind   = K_NONE;
    case (bus.csr_addr_i)
      12'h300: begin rd_val = mstatus_val;        kind = K_RW;     end
      12'h301: begin rd_val = MISA_VAL;           kind = K_RO_IGN; end
      12'h304: begin rd_val = mie_q;              kind = K_RW;     end
      12'h305: begin rd_val = mtvec_q;            kind = K_RW;     end
      12'h306: begin rd_val = mcounteren_q;       kind = K_RW;     end
      12'h341: begin rd_val = mepc_q;             kind = K_RW;     end
      12'h342: begin rd_val = mcause_q;           kind = K_RW;     end
      12'h344: begin rd_val = mip_val;            kind = K_RO_IGN; end
      12'hB00: begin rd_val = mcycle_q[31:0];     kind = K_RW;     end
      12'hB02: begin rd_val = minstret_q[31:0];   kind = K_RW;     end
      12'hB80: begin rd_val = mcycle_q[63:32];    kind = K_RW;     end
      12'hB82: begin rd_val = minstret_q[63:32];  kind = K_RW;     end
      12'hF11: begin rd_val = MVENDORID;          kind = K_ID;     end
      12'hF12: begin rd_val = MARCHID;            kind = K_ID;     end
      12'hF13: begin rd_val = MIMPID;             kind = K_ID;     end
      12'hF14: begin rd_val = HART_ID;            kind = K_ID;     end
      default: begin rd_val = '0;                 kind = K_NONE;   end
    endcase
  end

  always_comb begin
    case (bus.csr_op_i)
      2'b01:   wval = bus.csr_wdata_i;
      2'b10:   wval = rd_val | bus.csr_wdata_i;
      2'b11:   wval = rd_val & ~bus.csr_wdata_i;
      default: wval = rd_val;
    endcase
  end

  assign wr = bus.csr_en_i && (bus.csr_op_i != 2'b00) && (kind == K_RW);

  logic we_mstatus, we_mie, we_mtvec, we_mcnt, we_mepc, we_mcause;
  logic we_cyc_lo, we_cyc_hi, we_ins_lo, we_ins_hi;

  assign we_mstatus = wr && (bus.csr_addr_i == 12'h300);
  assign we_mie     = wr && (bus.csr_addr_i == 12'h304);
  assign we_mtvec   = wr && (bus.csr_addr_i == 12'h305);
  assign we_mcnt    = wr && (bus.csr_addr_i == 12'h306);
  assign we_mepc    = wr && (bus.csr_addr_i == 12'h341);
  assign we_mcause  = wr && (bus.csr_addr_i == 12'h342);
  assign we_cyc_lo  = wr && (bus.csr_addr_i == 12'hB00);
  assign we_cyc_hi  = wr && (bus.csr_addr_i == 12'hB80);
  assign we_ins_lo  = wr && (bus.csr_addr_i == 12'hB02);
  assign we_ins_hi  = wr && (bus.csr_addr_i == 12'hB82);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus.csr_rdata_o   <= '0;
      bus.csr_rvalid_o  <= 1'b0;
      bus.csr_illegal_o <= 1'b0;
    end else begin
      bus.csr_rvalid_o  <= bus.csr_en_i;
      bus.csr_illegal_o <= bus.csr_en_i &&
                           ((kind == K_NONE) || ((kind == K_ID) && (bus.csr_op_i != 2'b00)));
      if (bus.csr_en_i) bus.csr_rdata_o <= rd_val;
    end
  end

  // Trap entry beats mret, which beats a software write to mstatus.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else begin
      if (trap_i) begin
        mst_mpie_q <= mst_mie_q;
        mst_mie_q  <= 1'b0;
      end else if (mret_i) begin
        mst_mie_q  <= mst_mpie_q;
        mst_mpie_q <= 1'b1;
      end else if (we_mstatus) begin
        mst_mie_q  <= wval[3];
        mst_mpie_q <= wval[7];
      end
      if (trap_i)         mepc_q <= trap_pc_i & ALIGN4_MASK;
      else if (we_mepc)   mepc_q <= wval & ALIGN4_MASK;
      if (trap_i)         mcause_q <= trap_cause_i;
      else if (we_mcause) mcause_q <= wval;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mie_q        <= '0;
      mtvec_q      <= MTVEC_RST & ALIGN4_MASK;
      mcounteren_q <= '0;
    end else begin
      if (we_mie)   mie_q        <= wval & MIE_WMASK;
      if (we_mtvec) mtvec_q      <= wval & ALIGN4_MASK;
      if (we_mcnt)  mcounteren_q <= wval & MCNT_WMASK;
    end
  end

  // A write to either half freezes the whole 64-bit counter for that cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (we_cyc_lo || we_cyc_hi) begin
        if (we_cyc_lo) mcycle_q[31:0]  <= wval;
        if (we_cyc_hi) mcycle_q[63:32] <= wval;
      end else begin
        mcycle_q <= mcycle_q + 64'd1;
      end
      if (we_ins_lo || we_ins_hi) begin
        if (we_ins_lo) minstret_q[31:0]  <= wval;
        if (we_ins_hi) minstret_q[63:32] <= wval;
      end else if (instret_i) begin
        minstret_q <= minstret_q + 64'd1;
      end
    end
  end

  assign mtvec_o       = mtvec_q;
  assign mepc_o        = mepc_q;
  assign mie_o         = mst_mie_q;
  assign irq_pending_o = (|(mip_val & mie_q)) & mst_mie_q;

endmodule

// File: tb/tb_csr_file_m.sv
// Self-checking bench for csr_file_m: directed scenarios followed by random traffic,
// all compared against an architectural model of the CSR state.
module tb_csr_file_m;

  localparam logic [31:0] MISA  = 32'h40000100;
  localparam logic [31:0] HART  = 32'h00000003;
  localparam logic [31:0] MTVR  = 32'h00000100;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        instret_i, trap_i, mret_i;
  logic [31:0] trap_cause_i, trap_pc_i;
  logic [2:0]  irq_i;
  logic [31:0] mtvec_o, mepc_o;
  logic        mie_o, irq_pending_o;

  always #5 clk_i = ~clk_i;

  csr_file_m_if #(.XLEN(32)) bus ();

  csr_file_m #(
    .XLEN(32), .MISA_VAL(MISA), .MVENDORID(32'h0), .MARCHID(32'h0),
    .MIMPID(32'h0), .HART_ID(HART), .MTVEC_RST(MTVR)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .bus(bus),
    .instret_i(instret_i), .trap_i(trap_i), .trap_cause_i(trap_cause_i),
    .trap_pc_i(trap_pc_i), .mret_i(mret_i), .irq_i(irq_i),
    .mtvec_o(mtvec_o), .mepc_o(mepc_o), .mie_o(mie_o), .irq_pending_o(irq_pending_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural model state
  logic        m_mie, m_mpie;
  logic [31:0] m_mie_r, m_mtvec, m_mepc, m_mcause, m_mcnt;
  logic [63:0] m_cycle, m_instret;
  logic [31:0] e_rdata;
  logic        e_rvalid, e_illegal;

  function automatic void m_reset();
    m_mie = 1'b0; m_mpie = 1'b0;
    m_mie_r = 0; m_mtvec = MTVR; m_mepc = 0; m_mcause = 0; m_mcnt = 0;
    m_cycle = 0; m_instret = 0;
    e_rdata = 0; e_rvalid = 1'b0; e_illegal = 1'b0;
  endfunction

  function automatic logic [31:0] m_mip();
    return (irq_i[2] ? 32'h800 : 32'h0) + (irq_i[1] ? 32'h80 : 32'h0) + (irq_i[0] ? 32'h8 : 32'h0);
  endfunction

  // kind: 0 unmapped, 1 read-write, 2 read-only ignored, 3 id register
  function automatic void m_lookup(input logic [11:0] a, output logic [31:0] v, output int kind);
    v = 0; kind = 1;
    case (a)
      12'h300: v = 32'h1800 + (m_mpie ? 32'h80 : 32'h0) + (m_mie ? 32'h8 : 32'h0);
      12'h301: begin v = MISA; kind = 2; end
      12'h304: v = m_mie_r;
      12'h305: v = m_mtvec;
      12'h306: v = m_mcnt;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h344: begin v = m_mip(); kind = 2; end
      12'hB00: v = m_cycle[31:0];
      12'hB02: v = m_instret[31:0];
      12'hB80: v = m_cycle[63:32];
      12'hB82: v = m_instret[63:32];
      12'hF11, 12'hF12, 12'hF13: begin v = 0; kind = 3; end
      12'hF14: begin v = HART; kind = 3; end
      default: begin v = 0; kind = 0; end
    endcase
  endfunction

  function automatic void m_eval();
    logic [31:0] old, nv;
    logic [63:0] cyc_n, ins_n;
    int kind;
    logic wr;
    logic [11:0] a;
    a = bus.csr_addr_i;
    m_lookup(a, old, kind);
    if (bus.csr_en_i) begin
      e_rvalid  = 1'b1;
      e_rdata   = old;
      e_illegal = (kind == 0) || (kind == 3 && bus.csr_op_i != 2'b00);
    end else begin
      e_rvalid  = 1'b0;
      e_illegal = 1'b0;
    end
    wr = bus.csr_en_i && bus.csr_op_i != 2'b00 && kind == 1;
    case (bus.csr_op_i)
      2'b01:   nv = bus.csr_wdata_i;
      2'b10:   nv = old | bus.csr_wdata_i;
      default: nv = old & ~bus.csr_wdata_i;
    endcase
    cyc_n = m_cycle + 64'd1;
    ins_n = instret_i ? m_instret + 64'd1 : m_instret;
    if (wr && a == 12'hB00) cyc_n = {m_cycle[63:32], nv};
    if (wr && a == 12'hB80) cyc_n = {nv, m_cycle[31:0]};
    if (wr && a == 12'hB02) ins_n = {m_instret[63:32], nv};
    if (wr && a == 12'hB82) ins_n = {nv, m_instret[31:0]};
    m_cycle = cyc_n;
    m_instret = ins_n;
    if (trap_i) begin
      m_mpie = m_mie; m_mie = 1'b0;
    end else if (mret_i) begin
      m_mie = m_mpie; m_mpie = 1'b1;
    end else if (wr && a == 12'h300) begin
      m_mie = nv[3]; m_mpie = nv[7];
    end
    if (trap_i) begin
      m_mepc = trap_pc_i & 32'hFFFF_FFFC;
      m_mcause = trap_cause_i;
    end else begin
      if (wr && a == 12'h341) m_mepc = nv & 32'hFFFF_FFFC;
      if (wr && a == 12'h342) m_mcause = nv;
    end
    if (wr && a == 12'h304) m_mie_r = nv & 32'h888;
    if (wr && a == 12'h305) m_mtvec = nv & 32'hFFFF_FFFC;
    if (wr && a == 12'h306) m_mcnt  = nv & 32'h7;
  endfunction

  task automatic step();
    m_eval();
    @(posedge clk_i);
    #1;
    check("rvalid",  bus.csr_rvalid_o,  e_rvalid);
    check("illegal", bus.csr_illegal_o, e_illegal);
    check("rdata",   bus.csr_rdata_o,   e_rdata);
    check("mtvec_o", mtvec_o, m_mtvec);
    check("mepc_o",  mepc_o,  m_mepc);
    check("mie_o",   mie_o,   m_mie);
    check("irq_pending_o", irq_pending_o, ((m_mip() & m_mie_r) != 0) && m_mie);
    @(negedge clk_i);
    bus.csr_en_i = 1'b0; trap_i = 1'b0; mret_i = 1'b0; instret_i = 1'b0;
  endtask

  task automatic csr(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd);
    bus.csr_en_i = 1'b1; bus.csr_op_i = op; bus.csr_addr_i = addr; bus.csr_wdata_i = wd;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  logic [11:0] addr_tbl [18] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h306, 12'h341,
                                 12'h342, 12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82,
                                 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h7C0, 12'h123};

  initial begin
    bus.csr_en_i = 1'b0; bus.csr_op_i = 2'b00; bus.csr_addr_i = '0; bus.csr_wdata_i = '0;
    instret_i = 1'b0; trap_i = 1'b0; mret_i = 1'b0;
    trap_cause_i = '0; trap_pc_i = '0; irq_i = '0;
    m_reset();
    repeat (2) @(negedge clk_i);
    check("rst_rvalid",  bus.csr_rvalid_o, 1'b0);
    check("rst_illegal", bus.csr_illegal_o, 1'b0);
    check("rst_rdata",   bus.csr_rdata_o, 32'h0);
    check("rst_mtvec",   mtvec_o, MTVR);
    rst_i = 1'b0;

    // Reset values of read-only and status registers
    csr(2'b00, 12'h301, 0); check("misa", bus.csr_rdata_o, MISA);
    csr(2'b00, 12'hF14, 0); check("mhartid", bus.csr_rdata_o, HART);
    csr(2'b00, 12'h300, 0); check("mstatus_rst", bus.csr_rdata_o, 32'h1800);

    // Masked writes and set/clear
    csr(2'b01, 12'h305, 32'h0000_0203);
    csr(2'b00, 12'h305, 0); check("mtvec_align", bus.csr_rdata_o, 32'h200);
    csr(2'b10, 12'h304, 32'hFFFF_FFFF); check("mie_set_old", bus.csr_rdata_o, 32'h0);
    csr(2'b11, 12'h304, 32'h8);
    csr(2'b00, 12'h304, 0); check("mie_clr", bus.csr_rdata_o, 32'h880);

    // Illegal accesses
    csr(2'b01, 12'hF11, 32'h1234); check("id_wr_illegal", bus.csr_illegal_o, 1'b1);
    csr(2'b00, 12'h7C0, 0);
    check("unmapped_illegal", bus.csr_illegal_o, 1'b1);
    check("unmapped_rdata", bus.csr_rdata_o, 32'h0);
    csr(2'b00, 12'hF11, 0); check("mvendorid_kept", bus.csr_rdata_o, 32'h0);

    // Counter carry and write-suppressed increment
    csr(2'b01, 12'hB00, 32'hFFFF_FFFE);
    csr(2'b01, 12'hB80, 32'h0);
    idle(3);
    csr(2'b00, 12'hB80, 0); check("mcycleh_carry", bus.csr_rdata_o, 32'h1);
    csr(2'b00, 12'hB00, 0); check("mcycle_wrap", bus.csr_rdata_o, 32'h2);
    csr(2'b01, 12'hB00, 32'h10);
    csr(2'b00, 12'hB00, 0); check("mcycle_no_inc", bus.csr_rdata_o, 32'h10);

    // Trap entry and mret
    csr(2'b10, 12'h300, 32'h8);
    trap_i = 1'b1; trap_cause_i = 32'h8000_0007; trap_pc_i = 32'h1236;
    step();
    csr(2'b00, 12'h341, 0); check("trap_mepc", bus.csr_rdata_o, 32'h1234);
    csr(2'b00, 12'h342, 0); check("trap_mcause", bus.csr_rdata_o, 32'h8000_0007);
    csr(2'b00, 12'h300, 0); check("trap_mstatus", bus.csr_rdata_o, 32'h1880);
    mret_i = 1'b1; step();
    csr(2'b00, 12'h300, 0); check("mret_mstatus", bus.csr_rdata_o, 32'h1888);

    // Trap wins over a coincident mepc write
    trap_i = 1'b1; trap_cause_i = 32'h2; trap_pc_i = 32'h5556;
    bus.csr_en_i = 1'b1; bus.csr_op_i = 2'b01; bus.csr_addr_i = 12'h341;
    bus.csr_wdata_i = 32'hAAAA_AAA8;
    step();
    check("trap_vs_wr_rvalid", bus.csr_rvalid_o, 1'b1);
    csr(2'b00, 12'h341, 0); check("trap_vs_wr_mepc", bus.csr_rdata_o, 32'h5554);

    // Asynchronous reset while a read response is outstanding
    bus.csr_en_i = 1'b1; bus.csr_op_i = 2'b00; bus.csr_addr_i = 12'h300;
    m_eval();
    @(posedge clk_i);
    #1 check("pre_rst_rvalid", bus.csr_rvalid_o, 1'b1);
    #2 rst_i = 1'b1;
    #1;
    check("async_rst_rvalid", bus.csr_rvalid_o, 1'b0);
    check("async_rst_rdata",  bus.csr_rdata_o, 32'h0);
    check("async_rst_mtvec",  mtvec_o, MTVR);
    check("async_rst_mepc",   mepc_o, 32'h0);
    check("async_rst_mie",    mie_o, 1'b0);
    m_reset();
    @(negedge clk_i);
    bus.csr_en_i = 1'b0;
    rst_i = 1'b0;
    csr(2'b00, 12'hB00, 0); check("post_rst_mcycle", bus.csr_rdata_o, 32'h0);
    csr(2'b00, 12'h304, 0); check("post_rst_mie", bus.csr_rdata_o, 32'h0);
    csr(2'b00, 12'h300, 0); check("post_rst_mstatus", bus.csr_rdata_o, 32'h1800);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bus.csr_en_i    = ($urandom_range(0, 3) != 0);
      bus.csr_op_i    = 2'($urandom_range(0, 3));
      bus.csr_addr_i  = addr_tbl[$urandom_range(0, 17)];
      bus.csr_wdata_i = $urandom;
      instret_i       = $urandom_range(0, 1) == 1;
      trap_i          = ($urandom_range(0, 15) == 0);
      mret_i          = ($urandom_range(0, 11) == 0);
      trap_cause_i    = $urandom;
      trap_pc_i       = $urandom;
      irq_i           = 3'($urandom_range(0, 7));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected finish");
    $fatal(1, "timeout");
  end

endmodule
